// File: rtl/xalu_pkg.sv
// Shared constants for the nibble-serial ALU: opcodes, FSM encoding, slice width.
package xalu_pkg;

   localparam int unsigned NIBBLE_W = 4;
   localparam int unsigned OP_W     = 3;

   localparam logic [OP_W-1:0] OP_ADD   = 3'd0;
   localparam logic [OP_W-1:0] OP_AND   = 3'd1;
   localparam logic [OP_W-1:0] OP_OR    = 3'd2;
   localparam logic [OP_W-1:0] OP_XOR   = 3'd3;
   localparam logic [OP_W-1:0] OP_PASSA = 3'd4;
   localparam logic [OP_W-1:0] OP_PASSB = 3'd5;
   localparam logic [OP_W-1:0] OP_SHR   = 3'd6;
   localparam logic [OP_W-1:0] OP_SHL   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/xalu_slice.sv
// Combinational 4-bit ALU slice; carry/shift bits enter and leave on either side.
module xalu_slice
   import xalu_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic [OP_W-1:0]     f,
   input  logic                com,
   input  logic                ci_left,
   input  logic                ci_right,
   output logic [NIBBLE_W-1:0] d,
   output logic                co_left,
   output logic                co_right,
   output logic                equ,
   output logic                zero,
   output logic                neg_zero
);

   logic [NIBBLE_W:0]   sum;
   logic [NIBBLE_W-1:0] raw;

   // Function select; complement applies to the data nibble only, never the carries
   always_comb begin
      raw      = '0;
      co_left  = 1'b0;
      co_right = 1'b0;
      sum      = {1'b0, a} + {1'b0, b} + (NIBBLE_W+1)'(ci_right);
      case (f)
         OP_ADD: begin
            raw     = sum[NIBBLE_W-1:0];
            co_left = sum[NIBBLE_W];
         end
         OP_AND:   raw = a & b;
         OP_OR:    raw = a | b;
         OP_XOR:   raw = a ^ b;
         OP_PASSA: raw = a;
         OP_PASSB: raw = b;
         OP_SHR: begin
            raw      = {ci_left, a[NIBBLE_W-1:1]};
            co_right = a[0];
         end
         OP_SHL: begin
            raw     = {a[NIBBLE_W-2:0], ci_right};
            co_left = a[NIBBLE_W-1];
         end
         default: raw = '0;
      endcase
      d        = raw ^ {NIBBLE_W{com}};
      equ      = (a == b);
      zero     = (d == '0);
      neg_zero = &d;
   end

endmodule

// File: rtl/xalu_seq.sv
// Nibble-serial sequencer: steps one xalu_slice across a W-bit operation.
module xalu_seq
   import xalu_pkg::*;
#(
   parameter  int unsigned NIBBLES = 4,
   localparam int unsigned W       = NIBBLE_W * NIBBLES
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [OP_W-1:0] op,
   input  logic            com,
   input  logic [W-1:0]    a,
   input  logic [W-1:0]    b,
   input  logic            cin,
   output logic            busy,
   output logic            done,
   output logic [W-1:0]    result,
   output logic            cout,
   output logic            zero,
   output logic            neg_zero,
   output logic            equ
);

   localparam int unsigned IDX_W = $clog2(NIBBLES);

   state_t state_q, state_nx;

   logic [W-1:0]        a_q, b_q, shadow_q, shadow_nx;
   logic [OP_W-1:0]     op_q;
   logic                com_q, carry_q, carry_nx, equ_acc_q, equ_nx;
   logic [IDX_W-1:0]    idx_q, pos;
   logic                last_nib, accept;
   logic [NIBBLE_W-1:0] a_nib, b_nib, slice_d;
   logic                ci_left, ci_right, co_left, co_right, slice_equ;
   logic                slice_zero_unused, slice_neg_zero_unused;
   logic                busy_nx, done_nx;

   assign accept   = (state_q == ST_IDLE) && start;
   assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state_q;
      case (state_q)
         ST_IDLE: if (start)    state_nx = ST_RUN;
         ST_RUN:  if (last_nib) state_nx = ST_DONE;
         ST_DONE:               state_nx = ST_IDLE;
         default:               state_nx = ST_IDLE;
      endcase
   end

   // Status outputs decoded from the next state so the registered copies align with it
   always_comb begin
      busy_nx = 1'b0;
      done_nx = 1'b0;
      if (state_nx == ST_RUN)  busy_nx = 1'b1;
      if (state_nx == ST_DONE) done_nx = 1'b1;
   end

   // Registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= busy_nx;
         done <= done_nx;
      end
   end

   // Nibble position (SHR walks MSN first) and carry steering into the slice
   always_comb begin
      pos      = (op_q == OP_SHR) ? (IDX_W'(NIBBLES - 1) - idx_q) : idx_q;
      a_nib    = '0;
      b_nib    = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (pos == IDX_W'(i)) begin
            a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
            b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
         end
      end
      ci_right = ((op_q == OP_ADD) || (op_q == OP_SHL)) ? carry_q : 1'b0;
      ci_left  = (op_q == OP_SHR) ? carry_q : 1'b0;
   end

   xalu_slice u_slice (
      .a        (a_nib),
      .b        (b_nib),
      .f        (op_q),
      .com      (com_q),
      .ci_left  (ci_left),
      .ci_right (ci_right),
      .d        (slice_d),
      .co_left  (co_left),
      .co_right (co_right),
      .equ      (slice_equ),
      .zero     (slice_zero_unused),
      .neg_zero (slice_neg_zero_unused)
   );

   // Next carry, shadow with the current nibble merged in, and running equality
   always_comb begin
      carry_nx  = 1'b0;
      if ((op_q == OP_ADD) || (op_q == OP_SHL)) carry_nx = co_left;
      else if (op_q == OP_SHR)                  carry_nx = co_right;
      shadow_nx = shadow_q;
      for (int i = 0; i < NIBBLES; i++) begin
         if (pos == IDX_W'(i)) shadow_nx[i*NIBBLE_W +: NIBBLE_W] = slice_d;
      end
      equ_nx    = equ_acc_q & slice_equ;
   end

   // Operand latch, per-nibble stepping and final result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= OP_ADD;
         com_q     <= 1'b0;
         carry_q   <= 1'b0;
         idx_q     <= '0;
         shadow_q  <= '0;
         equ_acc_q <= 1'b0;
         result    <= '0;
         cout      <= 1'b0;
         zero      <= 1'b0;
         neg_zero  <= 1'b0;
         equ       <= 1'b0;
      end else if (accept) begin
         a_q       <= a;
         b_q       <= b;
         op_q      <= op;
         com_q     <= com;
         carry_q   <= cin;
         idx_q     <= '0;
         shadow_q  <= '0;
         equ_acc_q <= 1'b1;
      end else if (state_q == ST_RUN) begin
         carry_q   <= carry_nx;
         idx_q     <= idx_q + IDX_W'(1);
         shadow_q  <= shadow_nx;
         equ_acc_q <= equ_nx;
         if (last_nib) begin
            result   <= shadow_nx;
            cout     <= carry_nx;
            zero     <= (shadow_nx == '0);
            neg_zero <= &shadow_nx;
            equ      <= equ_nx;
         end
      end
   end

endmodule

// File: tb/tb_xalu_seq.sv
// Directed self-checking bench for xalu_seq at NIBBLES=4.
module tb_xalu_seq;
   import xalu_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic        com;
   logic [15:0] a, b;
   logic        cin;
   logic        busy, done, cout, zero, neg_zero, equ;
   logic [15:0] result;

   int checks = 0;
   int errors = 0;

   xalu_seq #(.NIBBLES(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .com      (com),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .zero     (zero),
      .neg_zero (neg_zero),
      .equ      (equ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch one operation and wait (bounded) for done; lat counts cycles after the start edge
   task automatic run_op(input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic cm, output int lat);
      @(posedge clk); #1;
      op = o; a = av; b = bv; cin = ci; com = cm; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL run_op_timeout: done=%b after %0d cycles, required 1", done, lat);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = OP_ADD; com = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, cout, zero, neg_zero, equ} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b required 000000", {busy, done, cout, zero, neg_zero, equ});
      end
      checks++;
      if (result !== 16'h0000) begin
         errors++;
         $display("FAIL reset_result: got %h required 0000", result);
      end
      rst = 1'b0;
   endtask

   task automatic test_add_timing();
      int bad_busy = 0;
      @(posedge clk); #1;
      op = OP_ADD; a = 16'h7FFF; b = 16'h0001; cin = 1'b0; com = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
         a = 16'hAAAA;
         @(posedge clk); #1;
      end
      checks++;
      if (bad_busy !== 0) begin
         errors++;
         $display("FAIL add_busy_window: %0d bad cycles in T+1..T+4, required 0", bad_busy);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL add_done_t5: done=%b busy=%b required done=1 busy=0", done, busy);
      end
      checks++;
      if ({result, cout, zero, neg_zero, equ} !== {16'h8000, 4'b0000}) begin
         errors++;
         $display("FAIL add_7fff_1: result=%h cout=%b zero=%b neg_zero=%b equ=%b required 8000 0 0 0 0",
                  result, cout, zero, neg_zero, equ);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || result !== 16'h8000) begin
         errors++;
         $display("FAIL add_done_pulse: done=%b result=%h required 0 8000", done, result);
      end
   endtask

   task automatic test_add_wrap();
      int lat;
      run_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
      checks++;
      if ({result, cout, zero, neg_zero} !== {16'h0000, 3'b110}) begin
         errors++;
         $display("FAIL add_wrap: result=%h cout=%b zero=%b neg_zero=%b required 0000 1 1 0",
                  result, cout, zero, neg_zero);
      end
      checks++;
      if (lat !== 5) begin
         errors++;
         $display("FAIL add_wrap_latency: got %0d required 5", lat);
      end
   endtask

   task automatic test_shift();
      int lat;
      run_op(OP_SHR, 16'h8001, 16'h0000, 1'b1, 1'b0, lat);
      checks++;
      if ({result, cout} !== {16'hC000, 1'b1}) begin
         errors++;
         $display("FAIL shr_8001: result=%h cout=%b required c000 1", result, cout);
      end
      run_op(OP_SHL, 16'h8001, 16'h0000, 1'b0, 1'b0, lat);
      checks++;
      if ({result, cout} !== {16'h0002, 1'b1}) begin
         errors++;
         $display("FAIL shl_8001: result=%h cout=%b required 0002 1", result, cout);
      end
      run_op(OP_SHL, 16'h1234, 16'h0000, 1'b1, 1'b0, lat);
      checks++;
      if ({result, cout} !== {16'h2469, 1'b0}) begin
         errors++;
         $display("FAIL shl_1234: result=%h cout=%b required 2469 0", result, cout);
      end
   endtask

   task automatic test_logic();
      int lat;
      run_op(OP_XOR, 16'h1234, 16'h1234, 1'b0, 1'b1, lat);
      checks++;
      if ({result, neg_zero, zero, equ, cout} !== {16'hFFFF, 4'b1010}) begin
         errors++;
         $display("FAIL xor_com: result=%h neg_zero=%b zero=%b equ=%b cout=%b required ffff 1 0 1 0",
                  result, neg_zero, zero, equ, cout);
      end
      run_op(OP_AND, 16'hF0F0, 16'h0FF0, 1'b1, 1'b0, lat);
      checks++;
      if ({result, equ, cout} !== {16'h00F0, 2'b00}) begin
         errors++;
         $display("FAIL and_f0f0: result=%h equ=%b cout=%b required 00f0 0 0", result, equ, cout);
      end
      run_op(OP_OR, 16'hA050, 16'h0A05, 1'b0, 1'b0, lat);
      checks++;
      if (result !== 16'hAA55) begin
         errors++;
         $display("FAIL or_a050: result=%h required aa55", result);
      end
      run_op(OP_PASSB, 16'h1111, 16'h5A5A, 1'b0, 1'b1, lat);
      checks++;
      if (result !== 16'hA5A5) begin
         errors++;
         $display("FAIL passb_com: result=%h required a5a5", result);
      end
   endtask

   task automatic test_back_to_back();
      int dones = 0;
      logic [15:0] first_res = '0;
      @(posedge clk); #1;
      op = OP_ADD; a = 16'h0003; b = 16'h0004; cin = 1'b0; com = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      op = OP_XOR; a = 16'h1111; b = 16'h2222; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (done === 1'b1) begin
            if (dones == 0) first_res = result;
            dones++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (dones !== 1) begin
         errors++;
         $display("FAIL b2b_done_count: got %0d required 1", dones);
      end
      checks++;
      if (first_res !== 16'hFFF8 || result !== 16'hFFF8 || cout !== 1'b0) begin
         errors++;
         $display("FAIL b2b_add_com: first=%h now=%h cout=%b required fff8 fff8 0",
                  first_res, result, cout);
      end
   endtask

   task automatic test_reset_mid_run();
      int dones = 0;
      int lat;
      @(posedge clk); #1;
      op = OP_ADD; a = 16'h0F0F; b = 16'h0101; cin = 1'b0; com = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({busy, done, cout, zero, neg_zero, equ} !== 6'b0 || result !== 16'h0000) begin
         errors++;
         $display("FAIL midrun_reset: busy=%b done=%b cout=%b zero=%b neg_zero=%b equ=%b result=%h required all 0",
                  busy, done, cout, zero, neg_zero, equ, result);
      end
      for (int c = 0; c < 10; c++) begin
         if (done === 1'b1 || busy === 1'b1) dones++;
         @(posedge clk); #1;
      end
      checks++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL midrun_no_done: %0d active cycles after reset, required 0", dones);
      end
      run_op(OP_ADD, 16'h1111, 16'h2222, 1'b1, 1'b0, lat);
      checks++;
      if ({result, cout, lat} !== {16'h3334, 1'b0, 32'd5}) begin
         errors++;
         $display("FAIL midrun_fresh_op: result=%h cout=%b lat=%0d required 3334 0 5", result, cout, lat);
      end
   endtask

   initial begin
      test_reset();
      test_add_timing();
      test_add_wrap();
      test_shift();
      test_logic();
      test_back_to_back();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
